risc_imem_loader: RTL and testbench

//  Writer side of the Risc_16_bit instruction memory. The processor only reads that memory.

---
 rtl/risc_imem_loader_if.sv | 23 ++
 rtl/risc_imem_loader.sv | 96 +++++++++
 tb/tb_risc_imem_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/risc_imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus for the loader.
// The loader is the slave on this bundle; the program source / memory side is the master.
interface risc_imem_loader_if #(
  parameter int COL    = 16,
  parameter int ADDR_W = 4
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [COL-1:0]    mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/risc_imem_loader.sv
// Instruction-memory loader for the Risc_16_bit core.
// Takes a byte stream (high byte first), writes ROW_I 16-bit words to
// addresses 0..ROW_I-1, then checks a trailing XOR checksum byte. The CPU is
// held until a load finishes with a good checksum. All outputs are Moore.
module risc_imem_loader #(
  parameter int COL    = 16,
  parameter int ROW_I  = 15,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  risc_imem_loader_if.slave  bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WR,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_I - 1);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_hi;
  logic [7:0]        r_chk;
  logic [ADDR_W-1:0] r_addr;
  logic [COL-1:0]    r_wdata;
  logic              w_ready;
  logic              w_xfer;
  logic              w_start_ok;

  assign w_ready    = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CHK);
  assign w_xfer     = w_ready && bus.byte_valid;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values, independent of block order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: start is only honoured when no load is in flight.
  always_comb begin
    // NOTE: default first, so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HI;
      S_HI:                  if (w_xfer) w_next = S_LO;
      S_LO:                  if (w_xfer) w_next = S_WR;
      S_WR:                  w_next = (r_addr == LAST_ADDR) ? S_CHK : S_HI;
      S_CHK:                 if (w_xfer) w_next = (bus.byte_in == r_chk) ? S_DONE : S_ERR;
      default:               w_next = S_IDLE;
    endcase
  end

  // Datapath: word assembly, write address and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi    <= '0;
      r_chk   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr <= '0;
        r_chk  <= '0;
      end else begin
        // Address advances on leaving WR and saturates at the last word.
        if ((r_state == S_WR) && (r_addr != LAST_ADDR)) r_addr <= r_addr + ADDR_W'(1);
        // Only data bytes feed the checksum; the checksum byte itself does not.
        if (w_xfer && ((r_state == S_HI) || (r_state == S_LO))) r_chk <= r_chk ^ bus.byte_in;
      end
      if (w_xfer && (r_state == S_HI)) r_hi    <= bus.byte_in;
      if (w_xfer && (r_state == S_LO)) r_wdata <= COL'({r_hi, bus.byte_in});
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.mem_we     = (r_state == S_WR);
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign cpu_hold       = (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign error          = (r_state == S_ERR);

endmodule

// File: tb/tb_risc_imem_loader.sv
// Self-checking bench for risc_imem_loader: table of directed loads, reset
// abort sequence, and randomized loads against a word/checksum model.
module tb_risc_imem_loader;
  localparam int COL     = 16;
  localparam int ROW_I   = 15;
  localparam int ADDR_W  = 4;
  localparam int N_BYTES = 2 * ROW_I + 1;
  localparam int TIMEOUT = 400;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;

  risc_imem_loader_if #(.COL(COL), .ADDR_W(ADDR_W)) bus ();

  risc_imem_loader #(.COL(COL), .ROW_I(ROW_I), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  string      tag     = "init";
  logic [7:0] tx_q[$];
  logic [15:0] exp_words[ROW_I];
  logic [15:0] cap[ROW_I];
  bit         written[ROW_I];
  int         we_cnt   = 0;
  int         addr_err = 0;

  typedef struct {
    logic [15:0] base;
    bit          ovr;
    logic [7:0]  ovr_chk;
    logic [7:0]  flip;
    int          k1;
    int          k2;
    bit          poke;
    bit          exp_done;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    else n_pass++;
  endtask

  // Write monitor: each mem_we must hit the next address in sequence.
  always @(posedge clk) begin
    #1;
    if (bus.mem_we === 1'b1) begin
      if (int'(bus.mem_addr) != we_cnt) addr_err++;
      else if (we_cnt < ROW_I) begin
        cap[we_cnt]     = bus.mem_wdata;
        written[we_cnt] = 1'b1;
      end
      we_cnt++;
    end
  end

  // Reference model: word list, byte stream (high byte first) and XOR checksum.
  task automatic build_load(input logic [15:0] base, input bit rnd, input bit ovr,
                            input logic [7:0] ovr_chk, input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    tx_q.delete();
    for (int i = 0; i < ROW_I; i++) begin
      exp_words[i] = rnd ? 16'($urandom) : base + 16'(i);
      tx_q.push_back(exp_words[i][15:8]);
      tx_q.push_back(exp_words[i][7:0]);
      x = x ^ exp_words[i][15:8] ^ exp_words[i][7:0];
    end
    tx_q.push_back(ovr ? ovr_chk : (x ^ flip));
  endtask

  // Pulses start, then streams tx_q. k1/k2: byte counts after which a
  // 10-cycle stall is inserted in the state that follows (LO after odd counts,
  // HI/CHK after even ones, i.e. one cycle later past WR).
  task automatic run_load(input int stall_pct, input int k1, input int k2, input bit poke,
                          input int abort_we, output int cycles, output int accepted);
    int since;
    int stall_left;
    bit k1_done;
    bit k2_done;
    bit fire;
    we_cnt = 0;
    addr_err = 0;
    for (int i = 0; i < ROW_I; i++) written[i] = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_hold", cpu_hold, 1);
    check("start_done", done, 0);
    check("start_err", error, 0);
    cycles = 0; accepted = 0; since = 0; stall_left = 0; k1_done = 0; k2_done = 0;
    while (!(done || error) && cycles < TIMEOUT) begin
      if (abort_we != 0 && we_cnt >= abort_we) break;
      if (!k1_done && k1 > 0 && accepted == k1 && since >= ((k1 % 2 == 0) ? 1 : 0)) begin
        stall_left = 10; k1_done = 1;
      end
      if (!k2_done && k2 > 0 && accepted == k2 && since >= ((k2 % 2 == 0) ? 1 : 0)) begin
        stall_left = 10; k2_done = 1;
      end
      start = poke && since == 1 && (accepted == 4 || accepted == 2 * ROW_I);
      if (stall_left > 0) begin
        bus.byte_valid = 1'b0;
        check("stall_we", bus.mem_we, 0);
        check("stall_rdy", bus.byte_ready, 1);
        stall_left--;
      end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
        bus.byte_valid = 1'b0;
      end else begin
        bus.byte_valid = (tx_q.size() > 0);
      end
      bus.byte_in = (bus.byte_valid && tx_q.size() > 0) ? tx_q[0] : 8'($urandom);
      fire = bus.byte_valid && bus.byte_ready;
      @(posedge clk);
      if (fire) begin
        void'(tx_q.pop_front());
        accepted++;
        since = 0;
      end else begin
        since++;
      end
      cycles++;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish_checks(input bit exp_done, input int exp_cycles,
                               input int cycles, input int accepted);
    int bad;
    bad = 0;
    for (int i = 0; i < ROW_I; i++) if (!written[i] || cap[i] !== exp_words[i]) bad++;
    check("no_timeout", cycles < TIMEOUT, 1);
    check("done", done, exp_done);
    check("error", error, !exp_done);
    check("cpu_hold", cpu_hold, !exp_done);
    check("we_count", we_cnt, ROW_I);
    check("addr_seq", addr_err, 0);
    check("word_mism", bad, 0);
    check("accepted", accepted, N_BYTES);
    check("leftover", tx_q.size(), 0);
    check("ready_end", bus.byte_ready, 0);
    if (exp_cycles >= 0) check("cycles", cycles, exp_cycles);
  endtask

  task automatic check_reset_values();
    check("rst_ready", bus.byte_ready, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
  endtask

  initial begin
    int cyc;
    int acc;
    bit bad_chk;
    //           base      ovr chk    flip   k1 k2  poke done cycles
    vecs[0] = '{16'h5000, 1, 8'h5F, 8'h00, 0, 0,  0,   1,   46};
    vecs[1] = '{16'h5000, 1, 8'h5E, 8'h00, 0, 0,  0,   0,   46};
    vecs[2] = '{16'h5000, 1, 8'h5F, 8'h00, 0, 0,  0,   1,   46};
    vecs[3] = '{16'h5000, 1, 8'h5F, 8'h00, 1, 30, 0,   1,   66};
    vecs[4] = '{16'h5000, 1, 8'h5F, 8'h00, 0, 0,  1,   1,   46};
    vecs[5] = '{16'h1234, 0, 8'h00, 8'h00, 0, 0,  0,   1,   46};
    vecs[6] = '{16'hFFF0, 0, 8'h00, 8'h80, 0, 0,  0,   0,   46};

    rst = 1'b1; start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    repeat (3) @(negedge clk);
    tag = "reset";
    check_reset_values();
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      tag = $sformatf("vec%0d", v);
      build_load(vecs[v].base, 0, vecs[v].ovr, vecs[v].ovr_chk, vecs[v].flip);
      run_load(0, vecs[v].k1, vecs[v].k2, vecs[v].poke, 0, cyc, acc);
      finish_checks(vecs[v].exp_done, vecs[v].exp_cycles, cyc, acc);
    end

    // Reset in the cycle after the 7th write aborts the load.
    tag = "abort";
    build_load(16'h5000, 0, 1, 8'h5F, 8'h00);
    run_load(0, 0, 0, 0, 7, cyc, acc);
    check("we_at_abort", we_cnt, 7);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("we_after", we_cnt, 7);
    check("hold_after", cpu_hold, 1);

    tag = "reload";
    build_load(16'h5000, 0, 1, 8'h5F, 8'h00);
    run_load(0, 0, 0, 0, 0, cyc, acc);
    finish_checks(1, 46, cyc, acc);

    for (int r = 0; r < 6; r++) begin
      tag = $sformatf("rand%0d", r);
      bad_chk = ($urandom_range(0, 2) == 0);
      build_load(16'h0000, 1, 0, 8'h00, bad_chk ? 8'($urandom_range(1, 255)) : 8'h00);
      run_load(30, 0, 0, 0, 0, cyc, acc);
      finish_checks(!bad_chk, -1, cyc, acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
